sha256d_nonce_sched: RTL and testbench

//  Search sequencer for sha256d_wrapper. Holds an 80-byte header loaded byte-serially, runs one double-SHA
//  per nonce, and serves the wrapper's word requests from the header (word 19 = live nonce). Checks each

---
 rtl/sha256d_nonce_sched_if.sv | 21 ++
 rtl/sha256d_nonce_sched.sv | 194 +++++++++++++++++++
 tb/tb_sha256d_nonce_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256d_nonce_sched_if.sv
// Word-request / digest channel between the nonce sequencer
// and the sha256d wrapper.
interface sha256d_nonce_sched_if;
  logic         sha_start;
  logic         sha_rdy;
  logic [31:0]  sha_data;
  logic [4:0]   sha_addr;
  logic         sha_rq;
  logic [255:0] sha_hash;
  logic         sha_done;

  modport master (
    output sha_start, sha_rdy, sha_data,
    input  sha_addr, sha_rq, sha_hash, sha_done
  );

  modport slave (
    input  sha_start, sha_rdy, sha_data,
    output sha_addr, sha_rq, sha_hash, sha_done
  );
endinterface

// File: rtl/sha256d_nonce_sched.sv
// Nonce search sequencer: holds an 80-byte header, runs one
// double-SHA per nonce and tests each digest for leading zeros.
module sha256d_nonce_sched #(
  parameter logic [31:0] NONCE_STEP = 32'd1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  input  logic [7:0]  zbits,
  input  logic        go,
  input  logic        abort,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic        timeout_err,
  output logic [31:0] found_nonce,
  output logic [31:0] tries,
  sha256d_nonce_sched_if.master sha
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_DRAIN, S_CHECK
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_t       r_state;
  logic [6:0]   r_ptr;
  logic [31:0]  r_hdr [20];
  logic [31:0]  r_nonce;
  logic [7:0]   r_zbits;
  logic         r_busy;
  logic         r_found;
  logic         r_exh;
  logic         r_tmo;
  logic [31:0]  r_fnonce;
  logic [31:0]  r_tries;
  logic         r_start;
  logic         r_rdy;
  logic [31:0]  r_data;
  logic         r_rq_d;
  logic [31:0]  r_wd;
  logic         r_hit;

  logic         w_edge;
  logic         w_serve;
  logic         w_wd_exp;
  logic [255:0] w_mask;
  logic         w_hit;
  logic [32:0]  w_next;
  logic [31:0]  w_word;

  assign w_edge   = sha.sha_rq & ~r_rq_d;
  assign w_serve  = w_edge &
                    ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_wd_exp = WD_EN && (r_wd == WD_LAST);
  // top zbits of the digest must be clear; zbits=0 gives an empty mask
  assign w_mask   = ~({256{1'b1}} >> r_zbits);
  assign w_hit    = ~|(sha.sha_hash & w_mask);
  assign w_next   = {1'b0, r_nonce} + {1'b0, NONCE_STEP};

  always_comb begin
    w_word = '0;
    if (sha.sha_addr == 5'd19)
      w_word = r_nonce;
    else if (sha.sha_addr < 5'd19)
      w_word = r_hdr[sha.sha_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      for (int i = 0; i < 20; i++)
        r_hdr[i] <= '0;
      r_nonce  <= '0;
      r_zbits  <= '0;
      r_busy   <= 1'b0;
      r_found  <= 1'b0;
      r_exh    <= 1'b0;
      r_tmo    <= 1'b0;
      r_fnonce <= '0;
      r_tries  <= '0;
      r_start  <= 1'b0;
      r_rdy    <= 1'b0;
      r_data   <= '0;
      r_rq_d   <= 1'b0;
      r_wd     <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_rdy   <= 1'b0;
      r_rq_d  <= sha.sha_rq;
      if (w_serve) begin
        r_rdy  <= 1'b1;
        r_data <= w_word;
      end
      unique case (r_state)
        S_IDLE: begin
          if (go) begin
            r_ptr   <= '0;
            r_zbits <= zbits;
            r_nonce <= r_hdr[19];
            r_found <= 1'b0;
            r_exh   <= 1'b0;
            r_tmo   <= 1'b0;
            r_tries <= '0;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_state <= S_START;
          end else if (cfg_we && (r_ptr < 7'd80)) begin
            r_hdr[r_ptr[6:2]][{~r_ptr[1:0], 3'b000} +: 8] <= cfg_wdata;
            r_ptr <= r_ptr + 7'd1;
          end
        end
        S_START: begin
          r_wd <= '0;
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd <= r_wd + 32'd1;
          if (sha.sha_done) begin
            if (abort) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_hit   <= w_hit;
              if (r_tries != '1)
                r_tries <= r_tries + 32'd1;
              r_state <= S_CHECK;
            end
          end else if (w_wd_exp) begin
            r_tmo   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (abort) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_wd <= r_wd + 32'd1;
          if (sha.sha_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_wd_exp) begin
            r_tmo   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_hit) begin
            r_found  <= 1'b1;
            r_fnonce <= r_nonce;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_next[32]) begin
            r_exh   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_nonce <= w_next[31:0];
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign found         = r_found;
  assign exhausted     = r_exh;
  assign timeout_err   = r_tmo;
  assign found_nonce   = r_fnonce;
  assign tries         = r_tries;
  assign sha.sha_start = r_start;
  assign sha.sha_rdy   = r_rdy;
  assign sha.sha_data  = r_data;
endmodule

// File: tb/tb_sha256d_nonce_sched.sv
// Directed bench for sha256d_nonce_sched with a behavioural
// wrapper model driving the word-request channel.
module tb_sha256d_nonce_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, go, abort;
  logic [7:0]  cfg_wdata, zbits;
  logic        busy, found, exhausted, timeout_err;
  logic [31:0] found_nonce, tries;

  logic        t_cfg_we, t_go, t_abort;
  logic [7:0]  t_cfg_wdata, t_zbits;
  logic        t_busy, t_found, t_exh, t_tmo;
  logic [31:0] t_fnonce, t_tries;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  sha256d_nonce_sched_if sif();
  sha256d_nonce_sched_if tif();

  sha256d_nonce_sched u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .zbits(zbits), .go(go), .abort(abort),
    .busy(busy), .found(found), .exhausted(exhausted),
    .timeout_err(timeout_err), .found_nonce(found_nonce),
    .tries(tries), .sha(sif)
  );

  sha256d_nonce_sched #(.TIMEOUT(16)) u_to (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(t_cfg_we), .cfg_wdata(t_cfg_wdata),
    .zbits(t_zbits), .go(t_go), .abort(t_abort),
    .busy(t_busy), .found(t_found), .exhausted(t_exh),
    .timeout_err(t_tmo), .found_nonce(t_fnonce),
    .tries(t_tries), .sha(tif)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sif.sha_start === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hdr(input logic [31:0] nonce);
    for (int b = 0; b < 80; b++) begin
      cfg_we = 1'b1;
      cfg_wdata = (b < 76) ? 8'(b) : nonce[8*(79-b) +: 8];
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (sif.sha_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (sif.sha_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: sha_start not seen within 200 cycles", nm);
    end
  endtask

  // Wrapper model: nreq word requests, then a digest with sha_done.
  task automatic wrap_hash(input int nreq, input logic [31:0] exp_nonce,
                           input logic [255:0] h, input bit lead);
    int a;
    logic [31:0] exp;
    if (lead) begin
      step();
      n_checks++;
      if (sif.sha_start !== 1'b0) begin
        n_fail++;
        $display("FAIL start_width: sha_start=%b required 0", sif.sha_start);
      end
    end
    for (int i = 0; i < nreq; i++) begin
      a = (i < 20) ? i : ((i == 20) ? 20 : 31);
      exp = (a == 19) ? exp_nonce :
            (a < 19) ? {8'(4*a), 8'(4*a+1), 8'(4*a+2), 8'(4*a+3)} : 32'h0;
      sif.sha_addr = 5'(a);
      sif.sha_rq = 1'b1;
      step();
      n_checks++;
      if (sif.sha_rdy !== 1'b1 || sif.sha_data !== exp) begin
        n_fail++;
        $display("FAIL word%0d: rdy=%b data=%h required rdy=1 data=%h",
                 a, sif.sha_rdy, sif.sha_data, exp);
      end
      sif.sha_rq = 1'b0;
      step();
      n_checks++;
      if (sif.sha_rdy !== 1'b0 || sif.sha_data !== exp) begin
        n_fail++;
        $display("FAIL hold%0d: rdy=%b data=%h required rdy=0 data=%h",
                 a, sif.sha_rdy, sif.sha_data, exp);
      end
    end
    sif.sha_hash = h;
    sif.sha_done = 1'b1;
    step();
    sif.sha_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({busy, found, exhausted, timeout_err, sif.sha_start, sif.sha_rdy}
        !== 6'b0 || found_nonce !== 0 || tries !== 0 || sif.sha_data !== 0) begin
      n_fail++;
      $display("FAIL reset: busy=%b found=%b exh=%b tmo=%b tries=%h required all 0",
               busy, found, exhausted, timeout_err, tries);
    end
    n_checks++;
    if ({t_busy, t_found, t_exh, t_tmo} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_to: flags=%b required 0000",
               {t_busy, t_found, t_exh, t_tmo});
    end
  endtask

  task automatic test_single_hit();
    load_hdr(32'h0000_0005);
    zbits = 8'd0;
    go = 1'b1;
    step();
    go = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy: busy=%b required 1", busy);
    end
    wait_start("t1_start");
    wrap_hash(22, 32'h0000_0005, {256{1'b1}}, 1'b1);
    step();
    n_checks++;
    if (found !== 1'b1 || found_nonce !== 32'h5 || tries !== 32'd1 ||
        busy !== 1'b0 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_result: found=%b nonce=%h tries=%0d busy=%b required 1/5/1/0",
               found, found_nonce, tries, busy);
    end
  endtask

  task automatic test_difficulty();
    logic [31:0] n;
    load_hdr(32'h0000_0003);
    zbits = 8'd8;
    start_cnt = 0;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = 32'd3 + 32'(k);
      wait_start("t2_start");
      wrap_hash(20, n, (n == 32'd7) ? {8'h00, {248{1'b1}}}
                                    : {8'h01, {248{1'b1}}}, 1'b1);
    end
    step();
    n_checks++;
    if (found !== 1'b1 || found_nonce !== 32'h7 || tries !== 32'd5) begin
      n_fail++;
      $display("FAIL t2_result: found=%b nonce=%h tries=%0d required 1/7/5",
               found, found_nonce, tries);
    end
    repeat (5) step();
    n_checks++;
    if (start_cnt !== 5) begin
      n_fail++;
      $display("FAIL t2_starts: starts=%0d required 5", start_cnt);
    end
  endtask

  task automatic test_exhaust();
    load_hdr(32'hFFFF_FFFE);
    zbits = 8'd255;
    go = 1'b1;
    step();
    go = 1'b0;
    wait_start("t3_start0");
    wrap_hash(20, 32'hFFFF_FFFE, {256{1'b1}}, 1'b1);
    wait_start("t3_start1");
    wrap_hash(20, 32'hFFFF_FFFF, {256{1'b1}}, 1'b1);
    step();
    n_checks++;
    if (exhausted !== 1'b1 || found !== 1'b0 || tries !== 32'd2 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_result: exh=%b found=%b tries=%0d busy=%b required 1/0/2/0",
               exhausted, found, tries, busy);
    end
  endtask

  task automatic test_abort();
    load_hdr(32'h0000_0010);
    zbits = 8'd255;
    start_cnt = 0;
    go = 1'b1;
    step();
    go = 1'b0;
    wait_start("t4_start0");
    wrap_hash(2, 32'h10, {256{1'b1}}, 1'b1);
    wait_start("t4_start1");
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    sif.sha_addr = 5'd19;
    sif.sha_rq = 1'b1;
    step();
    n_checks++;
    if (sif.sha_rdy !== 1'b1 || sif.sha_data !== 32'h11) begin
      n_fail++;
      $display("FAIL t4_drain_word: rdy=%b data=%h required 1/00000011",
               sif.sha_rdy, sif.sha_data);
    end
    sif.sha_rq = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_drain_busy: busy=%b required 1", busy);
    end
    sif.sha_hash = '0;
    sif.sha_done = 1'b1;
    step();
    sif.sha_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_end: busy=%b found=%b exh=%b required 0/0/0",
               busy, found, exhausted);
    end
    repeat (10) step();
    n_checks++;
    if (start_cnt !== 2) begin
      n_fail++;
      $display("FAIL t4_starts: starts=%0d required 2", start_cnt);
    end
    abort = 1'b1;
    repeat (2) step();
    abort = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || found !== 1'b0 || timeout_err !== 1'b0 ||
        start_cnt !== 2) begin
      n_fail++;
      $display("FAIL t4_idle_abort: busy=%b found=%b tmo=%b starts=%0d required 0/0/0/2",
               busy, found, timeout_err, start_cnt);
    end
  endtask

  task automatic test_timeout();
    t_zbits = 8'd0;
    t_go = 1'b1;
    step();
    t_go = 1'b0;
    n_checks++;
    if (tif.sha_start !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_start: sha_start=%b required 1", tif.sha_start);
    end
    repeat (16) step();
    n_checks++;
    if (t_busy !== 1'b1 || t_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_early: busy=%b tmo=%b required 1/0", t_busy, t_tmo);
    end
    step();
    n_checks++;
    if (t_busy !== 1'b0 || t_tmo !== 1'b1 || t_found !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_expire: busy=%b tmo=%b found=%b required 0/1/0",
               t_busy, t_tmo, t_found);
    end
  endtask

  task automatic test_reset_and_ignore();
    load_hdr(32'h0000_0030);
    zbits = 8'd255;
    go = 1'b1;
    step();
    go = 1'b0;
    wait_start("t6_start0");
    repeat (2) step();
    sif.sha_addr = 5'd3;
    sif.sha_rq = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b1 || sif.sha_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_pre: busy=%b rdy=%b required 1/1", busy, sif.sha_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, found, exhausted, timeout_err, sif.sha_start, sif.sha_rdy}
        !== 6'b0 || tries !== 0 || sif.sha_data !== 0 || found_nonce !== 0) begin
      n_fail++;
      $display("FAIL t6_async_rst: busy=%b rdy=%b data=%h tries=%h required all 0",
               busy, sif.sha_rdy, sif.sha_data, tries);
    end
    sif.sha_rq = 1'b0;
    #1 rst_n = 1'b1;
    step();
    load_hdr(32'h0000_0020);
    cfg_we = 1'b1;
    cfg_wdata = 8'hEE;
    step();
    zbits = 8'd0;
    cfg_wdata = 8'h99;
    go = 1'b1;
    step();
    go = 1'b0;
    cfg_we = 1'b0;
    wait_start("t6_start1");
    cfg_we = 1'b1;
    cfg_wdata = 8'h55;
    go = 1'b1;
    step();
    cfg_we = 1'b0;
    go = 1'b0;
    wrap_hash(21, 32'h0000_0020, {256{1'b1}}, 1'b0);
    step();
    n_checks++;
    if (found !== 1'b1 || found_nonce !== 32'h20 || tries !== 32'd1 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_result: found=%b nonce=%h tries=%0d busy=%b required 1/20/1/0",
               found, found_nonce, tries, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_wdata = '0; zbits = '0; go = 1'b0; abort = 1'b0;
    t_cfg_we = 1'b0; t_cfg_wdata = '0; t_zbits = '0;
    t_go = 1'b0; t_abort = 1'b0;
    sif.sha_addr = '0; sif.sha_rq = 1'b0;
    sif.sha_hash = '0; sif.sha_done = 1'b0;
    tif.sha_addr = '0; tif.sha_rq = 1'b0;
    tif.sha_hash = '0; tif.sha_done = 1'b0;
    test_reset();
    test_single_hit();
    test_difficulty();
    test_exhaust();
    test_abort();
    test_timeout();
    test_reset_and_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
